// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, read FSM states and CAS latency.
// CAS latency is 2 when SDRAM_RD_CL2_EN is defined, 3 otherwise.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CmdNop     = 4'b0111;
  localparam logic [3:0] CmdActive  = 4'b0011;
  localparam logic [3:0] CmdRead    = 4'b0101;
  localparam logic [3:0] CmdBStop   = 4'b0110;
  localparam logic [3:0] CmdPCharge = 4'b0010;

  localparam logic [1:0]  NopBa      = 2'b11;
  localparam logic [12:0] NopAddr    = 13'h1fff;
  localparam logic [12:0] PchAllAddr = 13'h0400;

`ifdef SDRAM_RD_CL2_EN
  localparam int unsigned CasLatency = 2;
`else
  localparam int unsigned CasLatency = 3;
`endif

  typedef enum logic [2:0] {
    RdIdle,
    RdActive,
    RdTrcd,
    RdRead,
    RdData,
    RdPch,
    RdTrp,
    RdEnd
  } rd_state_e;

endpackage

// File: rtl/sdram_rd_valid_pipe.sv
// Delays the READ-issue window by CasLatency+1 cycles into rd_ack and captures DQ words.
// Depth follows CasLatency (SDRAM_RD_CL2_EN selects CL=2).
module sdram_rd_valid_pipe
  import sdram_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rd_window,
  input  logic [15:0] rd_data_in,
  output logic        rd_ack,
  output logic [15:0] rd_sdram_data
);

  logic [CasLatency:0] vld_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_q         <= '0;
      rd_sdram_data <= '0;
    end else begin
      vld_q <= {vld_q[CasLatency-1:0], rd_window};
      // Tap CL-1 marks the cycle a word is on DQ; it is registered for the ack cycle.
      if (vld_q[CasLatency-1]) begin
        rd_sdram_data <= rd_data_in;
      end
    end
  end

  assign rd_ack = vld_q[CasLatency];

endmodule

// File: rtl/sdram_read.sv
// SDRAM read-burst engine: ACTIVE -> READ -> BURST STOP -> PRECHARGE with DQ capture.
// SDRAM_RD_CL2_EN selects CAS latency 2 (default 3) via sdram_pkg.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int unsigned TRCD_CLK = 2,
  parameter int unsigned TRP_CLK  = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_data_in,
  output logic [3:0]  rd_cmd,
  output logic [1:0]  rd_ba,
  output logic [12:0] rd_sdram_addr,
  output logic        rd_ack,
  output logic [15:0] rd_sdram_data,
  output logic        rd_end
);

  localparam logic [9:0] TrcdLast = 10'(TRCD_CLK - 1);
  localparam logic [9:0] TrpLast  = 10'(TRP_CLK);
  localparam logic [9:0] ClLast   = 10'(CasLatency - 1);

  rd_state_e   state_q, state_d;
  logic [9:0]  cnt_q;
  logic [9:0]  len_q;
  logic [23:0] addr_q;
  logic [9:0]  len_clamped;
  logic        start;
  logic        data_last;
  logic        pch_last;
  logic [3:0]  cmd_d;
  logic [1:0]  ba_d;
  logic [12:0] sdram_addr_d;

  assign start       = (state_q == RdIdle) && init_end && rd_en && (rd_burst_len != '0);
  assign len_clamped = (rd_burst_len > 10'd512) ? 10'd512 : rd_burst_len;
  assign data_last   = (cnt_q == len_q - 10'd1);
  assign pch_last    = (cnt_q == ClLast);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= RdIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 10'd1;
      if (start) begin
        addr_q <= rd_addr;
        len_q  <= len_clamped;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RdIdle:   if (start) state_d = RdActive;
      RdActive: state_d = RdTrcd;
      RdTrcd:   if (cnt_q == TrcdLast) state_d = RdRead;
      RdRead:   state_d = RdData;
      RdData:   if (data_last) state_d = RdPch;
      RdPch:    if (pch_last) state_d = RdTrp;
      RdTrp:    if (cnt_q == TrpLast) state_d = RdEnd;
      RdEnd:    state_d = RdIdle;
      default:  state_d = RdIdle;
    endcase
  end

  // Commands are computed from the current state and registered onto the pins.
  always_comb begin
    cmd_d        = CmdNop;
    ba_d         = NopBa;
    sdram_addr_d = NopAddr;
    unique case (state_q)
      RdActive: begin
        cmd_d        = CmdActive;
        ba_d         = addr_q[23:22];
        sdram_addr_d = addr_q[21:9];
      end
      RdRead: begin
        cmd_d        = CmdRead;
        ba_d         = addr_q[23:22];
        sdram_addr_d = {4'b0000, addr_q[8:0]};
      end
      RdData: begin
        if (data_last) begin
          cmd_d        = CmdBStop;
          ba_d         = rd_ba;
          sdram_addr_d = rd_sdram_addr;
        end
      end
      RdPch: begin
        if (pch_last) begin
          cmd_d        = CmdPCharge;
          ba_d         = addr_q[23:22];
          sdram_addr_d = PchAllAddr;
        end
      end
      default: begin
        cmd_d = CmdNop;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_cmd        <= CmdNop;
      rd_ba         <= NopBa;
      rd_sdram_addr <= NopAddr;
    end else begin
      rd_cmd        <= cmd_d;
      rd_ba         <= ba_d;
      rd_sdram_addr <= sdram_addr_d;
    end
  end

  assign rd_end = (state_q == RdEnd);

  sdram_rd_valid_pipe u_valid_pipe (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .rd_window     (state_q == RdData),
    .rd_data_in    (rd_data_in),
    .rd_ack        (rd_ack),
    .rd_sdram_data (rd_sdram_data)
  );

endmodule

// File: tb/tb_sdram_read.sv
// Directed bench for sdram_read with a simple DQ model; honours SDRAM_RD_CL2_EN for CL.
module tb_sdram_read;

`ifdef SDRAM_RD_CL2_EN
  localparam int CL = 2;
`else
  localparam int CL = 3;
`endif
  localparam int TRCD = 2;
  localparam int TRP  = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RDC = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PCH = 4'b0010;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        init_end;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_burst_len;
  logic [15:0] rd_data_in;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_ba;
  logic [12:0] rd_sdram_addr;
  logic        rd_ack;
  logic [15:0] rd_sdram_data;
  logic        rd_end;

  int n_checks = 0;
  int n_errors = 0;

  int t_act, t_rd, t_bs, t_pch, t_end, n_end, n_cmds;
  int ack_first, ack_last, ack_cnt, ack_gaps, data_err;
  logic [1:0]  act_ba, rd_ba_s, bs_ba, pch_ba;
  logic [12:0] act_addr, rd_addr_s, bs_addr, pch_addr;

  sdram_read #(
    .TRCD_CLK (TRCD),
    .TRP_CLK  (TRP)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .init_end      (init_end),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_burst_len  (rd_burst_len),
    .rd_data_in    (rd_data_in),
    .rd_cmd        (rd_cmd),
    .rd_ba         (rd_ba),
    .rd_sdram_addr (rd_sdram_addr),
    .rd_ack        (rd_ack),
    .rd_sdram_data (rd_sdram_data),
    .rd_end        (rd_end)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the cycle rd_en is raised; outputs are sampled on the falling edge.
  task automatic run_read(input logic [23:0] a, input logic [9:0] len, input int n_words,
                          input bit mid_pulse, input bit mid_reset);
    int c;
    int end_seen;
    t_act = -1; t_rd = -1; t_bs = -1; t_pch = -1; t_end = -1;
    n_end = 0; n_cmds = 0; ack_first = -1; ack_last = -1; ack_cnt = 0; ack_gaps = 0;
    data_err = 0; end_seen = -1;
    @(negedge sys_clk);
    rd_en = 1'b1; rd_addr = a; rd_burst_len = len; c = 0;
    for (int i = 0; i < n_words + 60; i++) begin
      @(negedge sys_clk);
      c++;
      if (c == 1) rd_en = 1'b0;
      if (rd_cmd !== NOP) n_cmds++;
      case (rd_cmd)
        ACT: begin t_act = c; act_ba = rd_ba; act_addr = rd_sdram_addr; end
        RDC: begin t_rd = c; rd_ba_s = rd_ba; rd_addr_s = rd_sdram_addr; end
        BST: begin t_bs = c; bs_ba = rd_ba; bs_addr = rd_sdram_addr; end
        PCH: begin t_pch = c; pch_ba = rd_ba; pch_addr = rd_sdram_addr; end
        default: ;
      endcase
      if (rd_end === 1'b1) begin n_end++; t_end = c; end_seen = c; end
      if (rd_ack === 1'b1) begin
        if (ack_cnt == 0) ack_first = c;
        else if (c != ack_last + 1) ack_gaps++;
        if (rd_sdram_data !== 16'hA000 + 16'(ack_cnt)) data_err++;
        ack_last = c;
        ack_cnt++;
      end
      if (mid_pulse && t_rd >= 0 && c == t_rd + 2) begin
        rd_en = 1'b1; rd_addr = 24'h123456; rd_burst_len = 10'd7;
      end
      if (mid_pulse && t_rd >= 0 && c == t_rd + 3) rd_en = 1'b0;
      if (mid_reset && t_rd >= 0 && c == t_rd + 2) begin
        sys_rst_n = 1'b0;
        #1;
        check("rst_mid.cmd", rd_cmd, NOP);
        check("rst_mid.ba", rd_ba, 2'b11);
        check("rst_mid.addr", rd_sdram_addr, 13'h1fff);
        check("rst_mid.ack", rd_ack, 1'b0);
        check("rst_mid.data", rd_sdram_data, 16'h0000);
        check("rst_mid.end", rd_end, 1'b0);
      end
      if (mid_reset && t_rd >= 0 && c == t_rd + 5) sys_rst_n = 1'b1;
      // DQ model: word k is driven during cycle T0+CL+k.
      if (t_rd >= 0 && c >= t_rd + CL && c < t_rd + CL + n_words)
        rd_data_in = 16'hA000 + 16'(c - t_rd - CL);
      else
        rd_data_in = 16'h5A5A;
      if (end_seen >= 0 && c >= end_seen + 2) break;
      if (mid_reset && t_rd >= 0 && c >= t_rd + 14) break;
    end
  endtask

  task automatic check_seq(input string tag, input int n, input logic [1:0] bank,
                           input logic [12:0] row, input logic [12:0] col);
    check({tag, ".t_act"}, t_act, 2);
    check({tag, ".act_ba"}, act_ba, bank);
    check({tag, ".act_addr"}, act_addr, row);
    check({tag, ".trcd"}, t_rd - t_act, TRCD + 1);
    check({tag, ".rd_ba"}, rd_ba_s, bank);
    check({tag, ".rd_addr"}, rd_addr_s, col);
    check({tag, ".ack_first"}, ack_first, t_rd + CL + 1);
    check({tag, ".ack_cnt"}, ack_cnt, n);
    check({tag, ".ack_gaps"}, ack_gaps, 0);
    check({tag, ".data_err"}, data_err, 0);
    check({tag, ".t_bs"}, t_bs, t_rd + n);
    check({tag, ".t_pch"}, t_pch, t_rd + n + CL);
    check({tag, ".pch_ba"}, pch_ba, bank);
    check({tag, ".pch_addr"}, pch_addr, 13'h0400);
    check({tag, ".t_end"}, t_end, t_rd + n + CL + TRP + 1);
    check({tag, ".n_end"}, n_end, 1);
    check({tag, ".n_cmds"}, n_cmds, 4);
  endtask

  initial begin
    sys_rst_n = 1'b0; init_end = 1'b0; rd_en = 1'b0;
    rd_addr = '0; rd_burst_len = 10'd4; rd_data_in = 16'h5A5A;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("reset.cmd", rd_cmd, NOP);
    check("reset.ba", rd_ba, 2'b11);
    check("reset.addr", rd_sdram_addr, 13'h1fff);
    check("reset.ack", rd_ack, 1'b0);
    check("reset.data", rd_sdram_data, 16'h0000);
    check("reset.end", rd_end, 1'b0);

    // Request before init completes must be ignored.
    rd_en = 1'b1; n_cmds = 0; n_end = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (rd_cmd !== NOP) n_cmds++;
      if (rd_end === 1'b1) n_end++;
    end
    rd_en = 1'b0;
    check("noinit.cmds", n_cmds, 0);
    check("noinit.end", n_end, 0);

    // Zero-length request must be ignored.
    init_end = 1'b1; rd_burst_len = 10'd0; rd_en = 1'b1; n_cmds = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      if (rd_cmd !== NOP) n_cmds++;
    end
    rd_en = 1'b0;
    check("len0.cmds", n_cmds, 0);

    run_read(24'h400A05, 10'd4, 4, 1'b0, 1'b0);
    check_seq("basic", 4, 2'd1, 13'h0005, 13'h0005);
    check("basic.bs_ba", bs_ba, 2'b11);
    check("basic.bs_addr", bs_addr, 13'h1fff);
    check("basic.hold", rd_sdram_data, 16'hA003);

    run_read(24'h000003, 10'd1, 1, 1'b0, 1'b0);
    check_seq("single", 1, 2'd0, 13'h0000, 13'h0003);
    check("single.bs_ba", bs_ba, 2'd0);
    check("single.bs_addr", bs_addr, 13'h0003);

    run_read(24'hFFFE00, 10'd512, 512, 1'b0, 1'b0);
    check_seq("page", 512, 2'd3, 13'h1fff, 13'h0000);

    run_read(24'h800200, 10'd1000, 512, 1'b0, 1'b0);
    check_seq("clamp", 512, 2'd2, 13'h0001, 13'h0000);

    run_read(24'h400A05, 10'd4, 4, 1'b1, 1'b0);
    check_seq("midpulse", 4, 2'd1, 13'h0005, 13'h0005);

    run_read(24'h400A05, 10'd4, 4, 1'b0, 1'b1);
    check("rst_mid.ack_cnt", ack_cnt, 0);
    check("rst_mid.n_end", n_end, 0);

    run_read(24'h00C010, 10'd2, 2, 1'b0, 1'b0);
    check_seq("after_rst", 2, 2'd0, 13'h0060, 13'h0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sdram_read.md
# sdram_read

Read-burst engine for the SDRAM controller: after initialisation, it accepts one read request (24-bit linear address, burst length) and runs the command sequence ACTIVE → READ → BURST STOP → PRECHARGE. It captures the returned words from the DQ bus and presents each word with a one-cycle-per-word acknowledge. It sits beside the write engine under the controller's arbiter, which muxes `rd_cmd`/`rd_ba`/`rd_sdram_addr` onto the SDRAM pins and routes `rd_ack`/`rd_sdram_data` to the read FIFO.

## Interface
Parameters:
- TRCD_CLK, 2, NOP cycles between ACTIVE and READ
- TRP_CLK, 2, NOP cycles between PRECHARGE and rd_end

Ports:
- sys_clk  in  1  controller clock; all logic on the rising edge
- sys_rst_n  in  1  reset: asynchronous, active-low
- init_end  in  1  SDRAM initialisation complete (level)
- rd_en  in  1  read request from the arbiter (level, sampled in RD_IDLE)
- rd_addr  in  24  {bank[23:22], row[21:9], col[8:0]}
- rd_burst_len  in  10  words to read, 1..512
- rd_data_in  in  16  SDRAM DQ input
- rd_cmd  out  4  {CS_n, RAS_n, CAS_n, WE_n}, registered
- rd_ba  out  2  bank address, registered
- rd_sdram_addr  out  13  SDRAM A[12:0], registered
- rd_ack  out  1  rd_sdram_data holds a valid word this cycle
- rd_sdram_data  out  16  captured read word, registered
- rd_end  out  1  one-cycle pulse: sequence finished, bus released

## Operation
- Command encodings: NOP 0111, ACTIVE 0011, READ 0101, B_STOP 0110, P_CHARGE 0010.
- States: RD_IDLE, RD_ACTIVE, RD_TRCD, RD_READ, RD_DATA, RD_PCH, RD_TRP, RD_END.
- Start condition: in RD_IDLE with init_end=1, rd_en=1 and rd_burst_len≠0, latch rd_addr and N=rd_burst_len, then go to RD_ACTIVE.
  - Lengths greater than 512 are clamped to 512.
  - rd_burst_len=0 is ignored; the block stays idle.
- rd_en, rd_addr and rd_burst_len are ignored outside RD_IDLE. Latched values are used for the whole sequence.
- ACTIVE: rd_ba=bank, rd_sdram_addr=row.
- READ: rd_ba=bank, rd_sdram_addr={4'b0000, col}. A10=0, so there is no auto-precharge.
- PRECHARGE: rd_ba=bank, rd_sdram_addr=13'h0400 (all banks).
- NOP cycles drive rd_ba=2'b11 and rd_sdram_addr=13'h1fff. B_STOP keeps the previous ba/addr.
- A single 10-bit cycle counter is cleared on each state entry. All state exits are counter compares against constants or the latched N.
- Reset mid-operation: return to RD_IDLE immediately with all outputs at reset values. No PRECHARGE is issued; the controller re-initialises.

## Timing
- Reset values: rd_cmd=NOP, rd_ba=2'b11, rd_sdram_addr=13'h1fff, rd_ack=0, rd_sdram_data=0, rd_end=0.
- Timeline, with T0 = the cycle rd_cmd==READ and CL = CAS latency:
  - ACTIVE on rd_cmd at T0−TRCD_CLK−1, NOP in between.
  - First rd_cmd change occurs 2 cycles after the accepting rd_en edge.
  - B_STOP at T0+N; NOP from T0+1 to T0+N−1 and from T0+N+1.
  - PRECHARGE at T0+N+CL, then TRP_CLK NOPs.
  - rd_end high exactly one cycle at T0+N+CL+TRP_CLK+1; RD_IDLE the following cycle.
- DQ word k (k=0..N−1) is valid at T0+CL+k and is registered into rd_sdram_data at T0+CL+k+1.
- rd_ack is high exactly for cycles T0+CL+1 … T0+CL+N, contiguous, N cycles in total.
- rd_sdram_data holds its last value when rd_ack=0 and is 0 after reset.
- A new request can be accepted in the cycle after rd_end at the earliest.

## Configuration
- SDRAM_RD_CL2_EN defined: CL=2. The init block's mode register must program CL=2.
- Not defined (default): CL=3.
- The macro changes only the ack delay-line depth and the PRECHARGE offset. Command ordering is unchanged.

## Structure
- Shared package sdram_pkg:
  - command encodings (NOP, ACTIVE, READ, B_STOP, P_CHARGE)
  - read state enum
  - CL constant derived from SDRAM_RD_CL2_EN
  - NOP bank/address constants 2'b11 / 13'h1fff
- Sub-module sdram_rd_valid_pipe: a CL+1 deep shift register that turns the READ-issue window (cycles T0..T0+N−1) into rd_ack. It also gates rd_data_in capture.

## Test plan
- Basic read at CL=3: rd_addr=24'h400A05, N=4, TRCD_CLK=TRP_CLK=2.
  - Response: ACTIVE ba=1 addr=13'h0005; READ 2 NOPs later with addr=13'h0005.
  - rd_ack for 4 cycles starting T0+4, data matching the DQ model (A0..A3).
  - B_STOP at T0+4, PRECHARGE at T0+7, rd_end at T0+10.
- Single word, N=1: B_STOP at T0+1; exactly one rd_ack cycle at T0+4.
- Full page, N=512, rd_addr=24'hFFFE00: ba=3, row=13'h1FFF.
  - 512 contiguous rd_ack cycles, column wrap handled by the device model.
- Gating:
  - rd_en=1 with init_end=0 → no command issued.
  - rd_burst_len=0 → stays in RD_IDLE, rd_cmd stays NOP.
  - rd_en pulsed mid-burst → ignored; exactly one rd_end.
- Reset mid-burst: assert sys_rst_n=0 at T0+2 → outputs at reset values within the same cycle, no further rd_ack. After release, a request with N=2 completes normally.
- Build with SDRAM_RD_CL2_EN, N=4: rd_ack at T0+3…T0+6, PRECHARGE at T0+6, rd_end at T0+9.
